mem_banked: RTL and testbench

- Parametrised single-port synchronous RAM built from 2^(ADDR_W-BANK_ADDR_W) identical banks of 2^BANK_ADDR_W words each. It is the general successor to the fixed 32x32-from-16x32 memory.
- Adds a post-reset clear engine, a busy flag, per-byte write enables and a registered read with a valid strobe.
- Sits behind any simple register-file or buffer client in the memories library.

---
 rtl/mem_banked.sv | 154 +++++++++++++++
 tb/tb_mem_banked.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_banked.sv
// Banked single-port synchronous RAM with a post-reset clear engine, byte write
// enables and a registered read. Define MEM_PARITY_EN to add per-byte even parity.
module mem_banked #(
   parameter int  DATA_W      = 32,
   parameter int  ADDR_W      = 5,
   parameter int  BANK_ADDR_W = 4,
   localparam int BE_W        = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              r_w,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BE_W-1:0]   be,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              parity_err
);

   localparam int NBANKS     = 1 << (ADDR_W - BANK_ADDR_W);
   localparam int BANK_DEPTH = 1 << BANK_ADDR_W;
   localparam int SEL_W      = (ADDR_W > BANK_ADDR_W) ? (ADDR_W - BANK_ADDR_W) : 1;
   localparam logic [BANK_ADDR_W-1:0] CNT_LAST = '1;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   state_t                 r_state;
   logic [BANK_ADDR_W-1:0] r_cnt;

   logic [SEL_W-1:0]       w_bank;
   logic [BANK_ADDR_W-1:0] w_idx;
   logic                   w_clr;
   logic                   w_wr;
   logic                   w_rd;
   logic [DATA_W-1:0]      w_bank_rd [NBANKS];
   logic [DATA_W-1:0]      w_rd_data;

   generate
      if (ADDR_W > BANK_ADDR_W) begin : g_sel
         assign w_bank = addr[ADDR_W-1:BANK_ADDR_W];
      end else begin : g_sel_single
         assign w_bank = '0;
      end
   endgenerate

   assign w_idx     = addr[BANK_ADDR_W-1:0];
   assign w_clr     = rst && (r_state == ST_CLEAR);
   assign w_wr      = rst && (r_state == ST_READY) && en && r_w;
   assign w_rd      = rst && (r_state == ST_READY) && en && !r_w;
   assign w_rd_data = w_bank_rd[w_bank];

`ifdef MEM_PARITY_EN
   logic [BE_W-1:0] w_bank_par [NBANKS];
   logic [BE_W-1:0] w_rd_par;

   function automatic logic [BE_W-1:0] byte_parity(input logic [DATA_W-1:0] word);
      logic [BE_W-1:0] par;
      par = '0;
      for (int i = 0; i < BE_W; i++) begin
         par[i] = ^word[8*i +: 8];
      end
      return par;
   endfunction

   assign w_rd_par = w_bank_par[w_bank];
`endif

   // One storage array per bank; the clear engine writes the same index in all of them.
   for (genvar g = 0; g < NBANKS; g++) begin : g_bank
      logic [DATA_W-1:0] r_mem [BANK_DEPTH];
      logic              w_sel;

      assign w_sel        = (w_bank == SEL_W'(g));
      assign w_bank_rd[g] = r_mem[w_idx];

      // NOTE: storage has no reset branch; it is zeroed by the clear engine instead,
      // which keeps it mappable to plain RAM and leaves it untouched on the reset edge.
      always_ff @(posedge clk) begin
         if (w_clr) begin
            r_mem[r_cnt] <= '0;
         end else if (w_wr && w_sel) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) r_mem[w_idx][8*i +: 8] <= d_in[8*i +: 8];
            end
         end
      end

`ifdef MEM_PARITY_EN
      logic [BE_W-1:0] r_par [BANK_DEPTH];

      assign w_bank_par[g] = r_par[w_idx];

      always_ff @(posedge clk) begin
         if (w_clr) begin
            r_par[r_cnt] <= '0;
         end else if (w_wr && w_sel) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) r_par[w_idx][i] <= ^d_in[8*i +: 8];
            end
         end
      end
`endif
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_CLEAR;
         r_cnt    <= '0;
         busy     <= 1'b1;
         d_out    <= '0;
         rd_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               rd_valid <= 1'b0;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_READY;
                  busy    <= 1'b0;
               end
            end
            ST_READY: begin
               rd_valid <= w_rd;
               if (w_rd) d_out <= w_rd_data;
            end
            default: begin
               r_state <= ST_CLEAR;
               r_cnt   <= '0;
               busy    <= 1'b1;
            end
         endcase
      end
   end

`ifdef MEM_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= w_rd && (|(w_rd_par ^ byte_parity(w_rd_data)));
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_banked.sv
// Self-checking bench for mem_banked: directed scenarios plus randomized traffic
// compared against a flat word-array reference model.
module tb_mem_banked;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int BEW   = 4;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          r_w;
   logic [AW-1:0] addr;
   logic [BEW-1:0] be;
   logic [DW-1:0] d_in;
   logic [DW-1:0] d_out;
   logic          rd_valid;
   logic          busy;
   logic          parity_err;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] ref_dout;
   logic          ref_valid;
   logic          ref_perr;

   mem_banked dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .r_w        (r_w),
      .addr       (addr),
      .be         (be),
      .d_in       (d_in),
      .d_out      (d_out),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "timeout");
   end

   // One access in READY: drive at negedge, take the edge, update the model, return at negedge.
   task automatic step(input logic e, input logic w, input logic [AW-1:0] a,
                       input logic [BEW-1:0] b, input logic [DW-1:0] d);
      en = e; r_w = w; addr = a; be = b; d_in = d;
      @(posedge clk);
      ref_valid = e && !w;
      if (e && !w) ref_dout = ref_mem[a];
      if (e && w) begin
         for (int i = 0; i < BEW; i++) begin
            if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
         end
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_dout  = '0;
      ref_valid = 1'b0;
      ref_perr  = 1'b0;
   endtask

   task automatic wait_clear(input string name, input logic drive_writes);
      int n;
      n = 0;
      en  = drive_writes;
      r_w = 1'b1;
      be  = '1;
      while (busy === 1'b1 && n < 100) begin
         addr = AW'($urandom);
         d_in = $urandom;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      en = 1'b0;
      checks++;
      if (n !== 16) begin
         failures++;
         $display("FAIL %s: busy cycles got %0d want 16", name, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; r_w = 1'b1; addr = '0; be = '1; d_in = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      checks++;
      if ({busy, rd_valid, parity_err, d_out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL reset_state: got busy=%b v=%b pe=%b d=%h want 1 0 0 0",
                  busy, rd_valid, parity_err, d_out);
      end
      rst = 1'b1;
      wait_clear("clear_length", 1'b1);
      step(1'b1, 1'b0, 5'd7, '0, '0);
      checks++;
      if ({busy, rd_valid, parity_err, d_out} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL clear_read7: got v=%b d=%h want 1 00000000", rd_valid, d_out);
      end
      for (int a = 0; a < DEPTH; a++) begin
         step(1'b1, 1'b0, AW'(a), '0, '0);
         checks++;
         if ({rd_valid, d_out} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL clear_all a=%0d: got v=%b d=%h want 1 00000000", a, rd_valid, d_out);
         end
      end
   endtask

   task automatic test_basic();
      logic [AW-1:0]  wa [3] = '{5'd0, 5'd15, 5'd5};
      logic [DW-1:0]  wd [3] = '{32'h00adc462, 32'h004da65c, 32'h00fa537c};
      logic [AW-1:0]  ra [3] = '{5'd15, 5'd1, 5'd5};
      logic [DW-1:0]  rd [3] = '{32'h004da65c, 32'h00000000, 32'h00fa537c};
      logic [DW-1:0]  held;
      held = d_out;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, wa[i], 4'hF, wd[i]);
         checks++;
         if ({rd_valid, d_out} !== {1'b0, held}) begin
            failures++;
            $display("FAIL basic_write%0d: got v=%b d=%h want 0 %h", i, rd_valid, d_out, held);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, ra[i], '0, '0);
         checks++;
         if ({rd_valid, d_out} !== {1'b1, rd[i]}) begin
            failures++;
            $display("FAIL basic_read a=%0d: got v=%b d=%h want 1 %h", ra[i], rd_valid, d_out, rd[i]);
         end
      end
      step(1'b0, 1'b0, 5'd0, '0, '0);
      checks++;
      if ({rd_valid, d_out} !== {1'b0, 32'h00fa537c}) begin
         failures++;
         $display("FAIL idle_hold: got v=%b d=%h want 0 00fa537c", rd_valid, d_out);
      end
   endtask

   task automatic test_bank_boundary();
      logic [AW-1:0] ba [4] = '{5'd15, 5'd16, 5'd31, 5'd0};
      logic [DW-1:0] bd [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h00adc462};
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, ba[i], 4'hF, bd[i]);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, ba[i], '0, '0);
         checks++;
         if ({rd_valid, d_out} !== {1'b1, bd[i]}) begin
            failures++;
            $display("FAIL bank_boundary a=%0d: got v=%b d=%h want 1 %h", ba[i], rd_valid, d_out, bd[i]);
         end
      end
   endtask

   task automatic test_byte_enable();
      step(1'b1, 1'b1, 5'd3, 4'hF, 32'hAABBCCDD);
      step(1'b1, 1'b1, 5'd3, 4'b0101, 32'h11223344);
      step(1'b1, 1'b0, 5'd3, '0, '0);
      checks++;
      if ({rd_valid, d_out} !== {1'b1, 32'hAA22CC44}) begin
         failures++;
         $display("FAIL byte_enable: got v=%b d=%h want 1 aa22cc44", rd_valid, d_out);
      end
      step(1'b1, 1'b1, 5'd3, 4'b0000, 32'h55667788);
      step(1'b1, 1'b0, 5'd3, '0, '0);
      checks++;
      if ({rd_valid, d_out} !== {1'b1, 32'hAA22CC44}) begin
         failures++;
         $display("FAIL be_zero: got v=%b d=%h want 1 aa22cc44", rd_valid, d_out);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, AW'($urandom), '0, '0);
         checks++;
         if ({busy, rd_valid, parity_err, d_out} !== {1'b0, 1'b1, 1'b0, ref_dout}) begin
            failures++;
            $display("FAIL back_to_back%0d: got v=%b d=%h want 1 %h", i, rd_valid, d_out, ref_dout);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), BEW'($urandom), $urandom);
         checks++;
         if ({busy, rd_valid, parity_err, d_out} !== {1'b0, ref_valid, ref_perr, ref_dout}) begin
            failures++;
            $display("FAIL random%0d a=%0d: got b=%b v=%b pe=%b d=%h want 0 %b %b %h",
                     i, addr, busy, rd_valid, parity_err, d_out, ref_valid, ref_perr, ref_dout);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 5'd5, 4'hF, 32'h00fa537c);
      step(1'b1, 1'b0, 5'd5, '0, '0);
      checks++;
      if ({rd_valid, d_out} !== {1'b1, 32'h00fa537c}) begin
         failures++;
         $display("FAIL pre_reset_read: got v=%b d=%h want 1 00fa537c", rd_valid, d_out);
      end
      rst = 1'b0; en = 1'b1; r_w = 1'b0; addr = 5'd5;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      checks++;
      if ({busy, rd_valid, parity_err, d_out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL mid_reset: got b=%b v=%b d=%h want 1 0 00000000", busy, rd_valid, d_out);
      end
      rst = 1'b1;
      wait_clear("mid_clear_length", 1'b0);
      step(1'b1, 1'b0, 5'd5, '0, '0);
      checks++;
      if ({rd_valid, d_out} !== {1'b1, 32'h0}) begin
         failures++;
         $display("FAIL after_clear5: got v=%b d=%h want 1 00000000", rd_valid, d_out);
      end
   endtask

`ifdef MEM_PARITY_EN
   task automatic test_parity();
      step(1'b1, 1'b1, 5'd9, 4'hF, 32'h00000001);
      step(1'b1, 1'b0, 5'd9, '0, '0);
      checks++;
      if ({rd_valid, parity_err, d_out} !== {1'b1, 1'b0, 32'h1}) begin
         failures++;
         $display("FAIL parity_clean: got v=%b pe=%b d=%h want 1 0 00000001", rd_valid, parity_err, d_out);
      end
      force dut.g_bank[0].r_par[9][0] = 1'b0;
      step(1'b1, 1'b0, 5'd9, '0, '0);
      checks++;
      if ({rd_valid, parity_err} !== 2'b11) begin
         failures++;
         $display("FAIL parity_inject: got v=%b pe=%b want 1 1", rd_valid, parity_err);
      end
      step(1'b0, 1'b0, 5'd9, '0, '0);
      checks++;
      if ({rd_valid, parity_err} !== 2'b00) begin
         failures++;
         $display("FAIL parity_idle: got v=%b pe=%b want 0 0", rd_valid, parity_err);
      end
      step(1'b1, 1'b0, 5'd3, '0, '0);
      checks++;
      if ({rd_valid, parity_err} !== 2'b10) begin
         failures++;
         $display("FAIL parity_other: got v=%b pe=%b want 1 0", rd_valid, parity_err);
      end
      release dut.g_bank[0].r_par[9][0];
      step(1'b1, 1'b1, 5'd9, 4'hF, 32'h00000001);
      step(1'b1, 1'b0, 5'd9, '0, '0);
      checks++;
      if ({rd_valid, parity_err} !== 2'b10) begin
         failures++;
         $display("FAIL parity_rewrite: got v=%b pe=%b want 1 0", rd_valid, parity_err);
      end
   endtask
`endif

   initial begin
      rst = 1'b0; en = 1'b0; r_w = 1'b0; addr = '0; be = '0; d_in = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_bank_boundary();
      test_byte_enable();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef MEM_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
